sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO, next generation of the team's 8-bit/16-deep FIFO.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 38 +++
 rtl/sync_fifo_param.sv | 121 ++++++++++++
 tb/tb_sync_fifo_param.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the parametrised synchronous FIFO.
// Widths are derived from DEPTH so every file sizes counters and pointers identically.
package fifo_pkg;

    // Occupancy must represent 0..depth inclusive, hence depth+1 states.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one synchronous write port and one synchronous read port.
// The read register is the only resettable state so the array still maps onto block RAM.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Output holds its last word when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read port, occupancy count, threshold flags and
// sticky overflow/underflow. A write at full is accepted only when paired with a read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              data_out,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PTR_W = fifo_ptr_w(DEPTH);
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
        end
        if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
            $error("sync_fifo_param: AF_LEVEL must lie in 1..DEPTH");
        end
        if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
            $error("sync_fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_valid_q;
    logic             empty_w, full_w;
    logic             rd_acc, wr_acc;

    // Flags depend only on the registered count, never on the request inputs.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        rd_acc      = rd_en & ~empty_w;
        wr_acc      = wr_en & (~full_w | rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (wr_en & ~wr_acc);
        underflow_d = underflow_q | (rd_en & ~rd_acc);

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_acc;
        end
    end

    // Writes during reset are suppressed so a reset mid-operation leaves no stray state.
    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_acc & ~rst),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (data_out)
    );

    assign rd_valid     = rd_valid_q;
    assign empty        = empty_w;
    assign full         = full_w;
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_sync_fifo_param;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         rd_valid, empty, full, almost_empty, almost_full;
    logic         overflow, underflow;
    logic [4:0]   count;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue plus the observable registered outputs.
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    bit           m_valid, m_ovf, m_unf;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Drive one cycle of requests and advance the model by the FIFO's queue semantics.
    task automatic do_cycle(input bit rs, input bit wr, input logic [W-1:0] d, input bit rd);
        bit rok, wok;
        rst = rs; wr_en = wr; data_in = d; rd_en = rd;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        end else begin
            rok = rd && (q.size() != 0);
            wok = wr && ((q.size() < D) || rok);
            if (rok) m_dout = q.pop_front();
            m_valid = rok;
            if (wok) q.push_back(d);
            if (wr && !wok) m_ovf = 1;
            if (rd && !rok) m_unf = 1;
        end
        #1;
        rst = 0; wr_en = 0; rd_en = 0;
    endtask

    task automatic test_reset();
        do_cycle(1, 0, '0, 0);
        do_cycle(0, 0, '0, 0);
        checks += 9;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b want 1", almost_empty); end
        if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b want 0", almost_full); end
        if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h want 00", data_out); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", underflow); end
        $display("test_reset done");
    endtask

    task automatic test_fill_drain();
        do_cycle(1, 0, '0, 0);
        for (int i = 1; i <= D; i++) begin
            do_cycle(0, 1, W'(i), 0);
            checks += 4;
            if (count !== 5'(i)) begin errors++; $display("FAIL fill_count i=%0d got %0d want %0d", i, count, i); end
            if (full !== (i == D)) begin errors++; $display("FAIL fill_full i=%0d got %b", i, full); end
            if (almost_full !== (i >= AF)) begin errors++; $display("FAIL fill_af i=%0d got %b", i, almost_full); end
            if (almost_empty !== (i <= AE)) begin errors++; $display("FAIL fill_ae i=%0d got %b", i, almost_empty); end
        end
        for (int i = 1; i <= D; i++) begin
            do_cycle(0, 0, '0, 1);
            checks += 3;
            if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid i=%0d got %b want 1", i, rd_valid); end
            if (data_out !== W'(i)) begin errors++; $display("FAIL drain_data i=%0d got %h want %h", i, data_out, W'(i)); end
            if (empty !== (i == D)) begin errors++; $display("FAIL drain_empty i=%0d got %b", i, empty); end
        end
        $display("test_fill_drain done");
    endtask

    task automatic test_full_rw();
        logic [W-1:0] exp;
        do_cycle(1, 0, '0, 0);
        for (int i = 1; i <= D; i++) do_cycle(0, 1, W'(i), 0);
        for (int k = 0; k < 20; k++) begin
            exp = q[0];
            do_cycle(0, 1, W'(8'hA0 + k), 1);
            checks += 4;
            if (count !== 5'd16) begin errors++; $display("FAIL fullrw_count k=%0d got %0d want 16", k, count); end
            if (data_out !== exp) begin errors++; $display("FAIL fullrw_data k=%0d got %h want %h", k, data_out, exp); end
            if (rd_valid !== 1'b1) begin errors++; $display("FAIL fullrw_valid k=%0d got %b want 1", k, rd_valid); end
            if (overflow !== 1'b0) begin errors++; $display("FAIL fullrw_overflow k=%0d got %b want 0", k, overflow); end
        end
        for (int i = 0; i < D; i++) begin
            exp = q[0];
            do_cycle(0, 0, '0, 1);
            checks++;
            if (data_out !== exp) begin errors++; $display("FAIL fullrw_drain i=%0d got %h want %h", i, data_out, exp); end
        end
        $display("test_full_rw done");
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp;
        do_cycle(1, 0, '0, 0);
        for (int i = 0; i < D; i++) do_cycle(0, 1, W'($urandom_range(0, 254)), 0);
        do_cycle(0, 1, 8'hFF, 0);
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", count); end
        for (int i = 0; i < D; i++) begin
            exp = q[0];
            do_cycle(0, 0, '0, 1);
            checks += 2;
            if (data_out === 8'hFF) begin errors++; $display("FAIL ovf_leak i=%0d got %h want not ff", i, data_out); end
            if (data_out !== exp) begin errors++; $display("FAIL ovf_drain i=%0d got %h want %h", i, data_out, exp); end
        end
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b want 1", empty); end
        $display("test_overflow done");
    endtask

    task automatic test_underflow();
        do_cycle(1, 0, '0, 0);
        do_cycle(0, 1, 8'h5A, 1);
        checks += 3;
        if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set got %b want 1", underflow); end
        if (count !== 5'd1) begin errors++; $display("FAIL unf_count got %0d want 1", count); end
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL unf_valid got %b want 0", rd_valid); end
        do_cycle(0, 0, '0, 1);
        checks += 4;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL unf_read_valid got %b want 1", rd_valid); end
        if (data_out !== 8'h5A) begin errors++; $display("FAIL unf_read_data got %h want 5a", data_out); end
        if (empty !== 1'b1) begin errors++; $display("FAIL unf_empty got %b want 1", empty); end
        if (underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky got %b want 1", underflow); end
        $display("test_underflow done");
    endtask

    task automatic test_mid_reset();
        do_cycle(1, 0, '0, 0);
        do_cycle(0, 0, '0, 1);
        for (int i = 0; i < 9; i++) do_cycle(0, 1, W'($urandom), 0);
        do_cycle(0, 0, '0, 1);
        do_cycle(0, 1, 8'h77, 0);
        checks += 2;
        if (count !== 5'd9) begin errors++; $display("FAIL mrst_pre_count got %0d want 9", count); end
        if (underflow !== 1'b1) begin errors++; $display("FAIL mrst_pre_unf got %b want 1", underflow); end
        do_cycle(1, 1, 8'h33, 1);
        checks += 5;
        if (count !== 5'd0) begin errors++; $display("FAIL mrst_count got %0d want 0", count); end
        if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got %b want 1", empty); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL mrst_unf got %b want 0", underflow); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL mrst_ovf got %b want 0", overflow); end
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b want 0", rd_valid); end
        do_cycle(0, 0, '0, 0);
        checks += 2;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid2 got %b want 0", rd_valid); end
        if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty2 got %b want 1", empty); end
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        bit wr, rd;
        int wbias;
        do_cycle(1, 0, '0, 0);
        for (int n = 0; n < 600; n++) begin
            wbias = ((n / 100) % 2 == 0) ? 75 : 30;
            wr = ($urandom_range(0, 99) < wbias);
            rd = ($urandom_range(0, 99) < 100 - wbias);
            do_cycle((n == 300), wr, W'($urandom), rd);
            checks += 6;
            if (count !== 5'(q.size())) begin errors++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, count, q.size()); end
            if (rd_valid !== m_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %b want %b", n, rd_valid, m_valid); end
            if (data_out !== m_dout) begin errors++; $display("FAIL rnd_data n=%0d got %h want %h", n, data_out, m_dout); end
            if ({empty, full} !== {q.size() == 0, q.size() == D}) begin
                errors++; $display("FAIL rnd_empty_full n=%0d got %b%b size %0d", n, empty, full, q.size());
            end
            if ({almost_empty, almost_full} !== {q.size() <= AE, q.size() >= AF}) begin
                errors++; $display("FAIL rnd_almost n=%0d got %b%b size %0d", n, almost_empty, almost_full, q.size());
            end
            if ({overflow, underflow} !== {m_ovf, m_unf}) begin
                errors++; $display("FAIL rnd_flags n=%0d got %b%b want %b%b", n, overflow, underflow, m_ovf, m_unf);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_overflow();
        test_underflow();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
